layer_input_tracker: RTL

LAYER_INPUT_TRACKER -- requirements
Module: layer_input_tracker

---
 rtl/layer_input_tracker.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/layer_input_tracker.sv
// ============================================================================
// Module  : layer_input_tracker
// Brief   : Tracks pixel arrival for one frame and flags when the next
//           convolution window has all of its input pixels available.
// Revision: 1.0
// ============================================================================
`default_nettype none

module layer_input_tracker #(
  parameter int IMG_W  = 10,
  parameter int IMG_H  = 10,
  parameter int KERNEL = 3,
  parameter int LEAD   = 1,
  parameter int CNT_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             conv_start,
  input  logic             pix_valid,
  input  logic             win_consume,
  output logic             layer_input_ready,
  output logic [CNT_W-1:0] pix_count,
  output logic [CNT_W-1:0] win_row,
  output logic [CNT_W-1:0] win_col,
  output logic             busy,
  output logic             frame_done,
  output logic             err_overflow,
  output logic             err_underflow
);

  localparam int OUT_W     = IMG_W - KERNEL + 1;
  localparam int OUT_H     = IMG_H - KERNEL + 1;
  localparam int TOTAL_PIX = IMG_W * IMG_H;

  localparam logic [CNT_W-1:0] TOTAL_C    = CNT_W'(TOTAL_PIX);
  localparam logic [CNT_W-1:0] IMG_W_C    = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] ROW_OFS_C  = CNT_W'(KERNEL - 1);
  localparam logic [CNT_W-1:0] COL_OFS_C  = CNT_W'(KERNEL - LEAD);
  localparam logic [CNT_W-1:0] LAST_COL_C = CNT_W'(OUT_W - 1);
  localparam logic [CNT_W-1:0] OUT_H_C    = CNT_W'(OUT_H);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pix_count_q, pix_count_d;
  logic [CNT_W-1:0] win_row_q, win_row_d;
  logic [CNT_W-1:0] win_col_q, win_col_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unf_q, err_unf_d;

  logic [CNT_W-1:0] need;
  logic             win_left;
  logic             ready;

  // Pixel count (1-based) of the bottom-right pixel of the pending window,
  // pulled in by LEAD so downstream registering is hidden.
  assign need     = (win_row_q + ROW_OFS_C) * IMG_W_C + win_col_q + COL_OFS_C;
  assign win_left = (win_row_q < OUT_H_C);
  assign ready    = (state_q == S_FILL) && win_left && (pix_count_q >= need);

  always_comb begin
    state_d     = state_q;
    pix_count_d = pix_count_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    err_ovf_d   = err_ovf_q;
    err_unf_d   = err_unf_q;

    if (win_consume && !ready) begin
      err_unf_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (conv_start) begin
          state_d     = S_FILL;
          pix_count_d = '0;
          win_row_d   = '0;
          win_col_d   = '0;
          err_ovf_d   = 1'b0;
          err_unf_d   = 1'b0;
        end else if (pix_valid) begin
          err_ovf_d = 1'b1;
        end
      end

      S_FILL: begin
        if (pix_valid) begin
          if (pix_count_q < TOTAL_C) begin
            pix_count_d = pix_count_q + 1'b1;
          end else begin
            err_ovf_d = 1'b1;
          end
        end
        if (win_consume && ready) begin
          if (win_col_q == LAST_COL_C) begin
            win_col_d = '0;
            win_row_d = win_row_q + 1'b1;
          end else begin
            win_col_d = win_col_q + 1'b1;
          end
        end
        // Row index past the last output row means every window was consumed.
        if ((pix_count_d == TOTAL_C) && (win_row_d == OUT_H_C)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (pix_valid) begin
          err_ovf_d = 1'b1;
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pix_count_q <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_count_q <= pix_count_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      err_ovf_q   <= err_ovf_d;
      err_unf_q   <= err_unf_d;
    end
  end

  assign layer_input_ready = ready;
  assign pix_count         = pix_count_q;
  assign win_row           = win_row_q;
  assign win_col           = win_col_q;
  assign busy              = (state_q != S_IDLE);
  assign frame_done        = (state_q == S_DONE);
  assign err_overflow      = err_ovf_q;
  assign err_underflow     = err_unf_q;

endmodule

`default_nettype wire
